// File: rtl/decstage_pkg.sv
// Shared types and formatting helpers for the MIPS decode stage.
// Helpers work at MAX_W bits; callers size-cast the result to their datapath width.
package decstage_pkg;

  localparam int MAX_W = 128;

  typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_BR} imm_mode_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_BYTE, SZ_HALF} size_t;

  // Size encoding 2'b11 falls into the default branches and behaves as a word.
  function automatic logic [MAX_W-1:0] load_format(input logic [MAX_W-1:0] mem,
                                                   input size_t size,
                                                   input logic zext,
                                                   input logic [7:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = mem[8*off +: 8];
    h = mem[16*(off >> 1) +: 16];
    case (size)
      SZ_BYTE: return {{(MAX_W-8){~zext & b[7]}}, b};
      SZ_HALF: return {{(MAX_W-16){~zext & h[15]}}, h};
      default: return mem;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] store_format(input logic [MAX_W-1:0] d,
                                                    input size_t size);
    case (size)
      SZ_BYTE: return {(MAX_W/8){d[7:0]}};
      SZ_HALF: return {(MAX_W/16){d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] imm_format(input logic [15:0] imm,
                                                  input imm_mode_t mode);
    logic [MAX_W-1:0] sext;
    sext = {{(MAX_W-16){imm[15]}}, imm};
    case (mode)
      IMM_ZEXT: return {{(MAX_W-16){1'b0}}, imm};
      IMM_LUI:  return sext << 16;
      IMM_BR:   return sext << 2;
      default:  return sext;
    endcase
  endfunction

endpackage

// File: rtl/decstage_pipe_if.sv
// Decode-stage bus: IF/ID inputs, MEM/WB write-back return and ID/EX outputs.
interface decstage_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
);
  localparam int ADDR_W = $clog2(REG_CNT);
  localparam int OFF_W  = $clog2(DATA_W / 8);

  logic [31:0]       instr;
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [1:0]        imm_mode;
  logic              rf_b_sel;
  logic [1:0]        st_size;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_sel;
  logic [DATA_W-1:0] wb_alu;
  logic [DATA_W-1:0] wb_mem;
  logic [1:0]        wb_size;
  logic              wb_unsigned;
  logic [OFF_W-1:0]  wb_off;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [ADDR_W-1:0] ex_rs_addr;
  logic [ADDR_W-1:0] ex_rt_addr;
  logic              err_misalign;

  modport master (
    output instr, in_valid, stall, flush, imm_mode, rf_b_sel, st_size,
           wb_en, wb_addr, wb_sel, wb_alu, wb_mem, wb_size, wb_unsigned, wb_off,
    input  ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs_addr, ex_rt_addr, err_misalign
  );

  modport slave (
    input  instr, in_valid, stall, flush, imm_mode, rf_b_sel, st_size,
           wb_en, wb_addr, wb_sel, wb_alu, wb_mem, wb_size, wb_unsigned, wb_off,
    output ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs_addr, ex_rt_addr, err_misalign
  );
endinterface

// File: rtl/reg_file_bp.sv
// Two-read, one-write register file with r0 hard-wired to zero and
// same-cycle write-to-read bypass.
module reg_file_bp #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // Bypass lets a reader in the write cycle see the value being committed.
  always_comb begin
    ra_data = regs[ra_addr];
    if (ra_addr == '0)                ra_data = '0;
    else if (we && wa == ra_addr)     ra_data = wd;
  end

  always_comb begin
    rb_data = regs[rb_addr];
    if (rb_addr == '0)                rb_data = '0;
    else if (we && wa == rb_addr)     rb_data = wd;
  end

endmodule

// File: rtl/decstage_pipe.sv
// MIPS instruction-decode stage: register file, immediate/store formatting
// and the ID/EX pipeline register with stall refresh.
module decstage_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  decstage_pipe_if.slave bus
);
  import decstage_pkg::*;

  localparam int ADDR_W = $clog2(REG_CNT);

  logic [ADDR_W-1:0] rs_addr, rt_addr;
  logic [DATA_W-1:0] rs_data, rb_data, wb_data, st_data, imm_data;
  logic              rs_hit, rt_hit;
  logic              unused_instr;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [ADDR_W-1:0] ex_rs_addr, ex_rt_addr;
  size_t             ex_st_size;
  logic              err_misalign;

  assign rs_addr      = bus.instr[21 +: ADDR_W];
  assign rt_addr      = bus.rf_b_sel ? bus.instr[16 +: ADDR_W] : bus.instr[11 +: ADDR_W];
  assign unused_instr = ^bus.instr[31:26];

  assign wb_data = bus.wb_sel
                   ? DATA_W'(load_format(MAX_W'(bus.wb_mem), size_t'(bus.wb_size),
                                         bus.wb_unsigned, 8'(bus.wb_off)))
                   : bus.wb_alu;

  reg_file_bp #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (rs_addr),
    .rb_addr (rt_addr),
    .we      (bus.wb_en),
    .wa      (bus.wb_addr),
    .wd      (wb_data),
    .ra_data (rs_data),
    .rb_data (rb_data)
  );

  assign st_data  = DATA_W'(store_format(MAX_W'(rb_data), size_t'(bus.st_size)));
  assign imm_data = DATA_W'(imm_format(bus.instr[15:0], imm_mode_t'(bus.imm_mode)));

  // A stalled instruction must not miss a write-back to a register it already read.
  assign rs_hit = ex_valid && bus.wb_en && bus.wb_addr == ex_rs_addr && ex_rs_addr != '0;
  assign rt_hit = ex_valid && bus.wb_en && bus.wb_addr == ex_rt_addr && ex_rt_addr != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs_addr <= '0;
      ex_rt_addr <= '0;
      ex_st_size <= SZ_WORD;
    end else if (bus.flush) begin
      ex_valid   <= 1'b0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs_addr <= '0;
      ex_rt_addr <= '0;
      ex_st_size <= SZ_WORD;
    end else if (bus.stall) begin
      if (rs_hit) ex_rs_data <= wb_data;
      if (rt_hit) ex_rt_data <= DATA_W'(store_format(MAX_W'(wb_data), ex_st_size));
    end else begin
      ex_valid   <= bus.in_valid;
      ex_rs_data <= rs_data;
      ex_rt_data <= st_data;
      ex_imm     <= imm_data;
      ex_rs_addr <= rs_addr;
      ex_rt_addr <= rt_addr;
      ex_st_size <= size_t'(bus.st_size);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_misalign <= 1'b0;
    end else if (bus.wb_en && bus.wb_sel && bus.wb_size == 2'b10 && bus.wb_off[0]) begin
      err_misalign <= 1'b1;
    end
  end

  assign bus.ex_valid     = ex_valid;
  assign bus.ex_rs_data   = ex_rs_data;
  assign bus.ex_rt_data   = ex_rt_data;
  assign bus.ex_imm       = ex_imm;
  assign bus.ex_rs_addr   = ex_rs_addr;
  assign bus.ex_rt_addr   = ex_rt_addr;
  assign bus.err_misalign = err_misalign;

endmodule

// File: tb/tb_decstage_pipe.sv
// Self-checking bench for decstage_pipe: directed scenarios plus random traffic
// compared against an arithmetic reference model of the decode stage.
module tb_decstage_pipe;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  decstage_pipe_if #(.DATA_W(32), .REG_CNT(32)) bus ();

  decstage_pipe #(.DATA_W(32), .REG_CNT(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_rs, m_rt, m_imm;
  logic [4:0]  m_rsa, m_rta;
  logic [1:0]  m_st;
  logic        m_err;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_valid = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_rsa = 0; m_rta = 0; m_st = 0; m_err = 0;
  endtask

  task automatic setIdle();
    bus.instr = '0; bus.in_valid = 0; bus.stall = 0; bus.flush = 0; bus.imm_mode = 0;
    bus.rf_b_sel = 0; bus.st_size = 0; bus.wb_en = 0; bus.wb_addr = 0; bus.wb_sel = 0;
    bus.wb_alu = '0; bus.wb_mem = '0; bus.wb_size = 0; bus.wb_unsigned = 0; bus.wb_off = 0;
  endtask

  function automatic logic [31:0] mkInstr(input int rs, input int rt, input int rd, input int imm);
    return 32'((rs << 21) | (rt << 16) | (rd << 11) | (imm & 16'hFFFF));
  endfunction

  function automatic logic [31:0] storeRep(input logic [31:0] v, input logic [1:0] sz);
    if (sz == 2'd1) return (v & 32'hFF) * 32'h01010101;
    if (sz == 2'd2) return (v & 32'hFFFF) * 32'h00010001;
    return v;
  endfunction

  function automatic logic [31:0] readReg(input logic [4:0] a, input logic [31:0] wd);
    if (a == 0) return 0;
    if (bus.wb_en && bus.wb_addr == a) return wd;
    return m_rf[a];
  endfunction

  // Predict the next ID/EX state from the current inputs, clock once, compare.
  task automatic applyStimulus();
    logic [31:0] wd, lane, sx, imm16, n_rs, n_rt, n_imm;
    logic [4:0]  rsa, rta, n_rsa, n_rta;
    logic [1:0]  n_st;
    logic        n_valid;
    wd = bus.wb_alu;
    if (bus.wb_sel) begin
      case (bus.wb_size)
        2'd1: begin
          lane = (bus.wb_mem >> (8 * bus.wb_off)) & 32'hFF;
          wd = (!bus.wb_unsigned && lane >= 32'h80) ? lane - 32'h100 : lane;
        end
        2'd2: begin
          lane = (bus.wb_mem >> (16 * (bus.wb_off / 2))) & 32'hFFFF;
          wd = (!bus.wb_unsigned && lane >= 32'h8000) ? lane - 32'h10000 : lane;
        end
        default: wd = bus.wb_mem;
      endcase
    end
    rsa = bus.instr[25:21];
    rta = bus.rf_b_sel ? bus.instr[20:16] : bus.instr[15:11];
    imm16 = {16'h0, bus.instr[15:0]};
    sx = (imm16 >= 32'h8000) ? imm16 - 32'h10000 : imm16;
    n_valid = m_valid; n_rs = m_rs; n_rt = m_rt; n_imm = m_imm;
    n_rsa = m_rsa; n_rta = m_rta; n_st = m_st;
    if (bus.flush) begin
      n_valid = 0; n_rs = 0; n_rt = 0; n_imm = 0; n_rsa = 0; n_rta = 0; n_st = 0;
    end else if (bus.stall) begin
      if (m_valid && bus.wb_en && bus.wb_addr == m_rsa && m_rsa != 0) n_rs = wd;
      if (m_valid && bus.wb_en && bus.wb_addr == m_rta && m_rta != 0) n_rt = storeRep(wd, m_st);
    end else begin
      n_valid = bus.in_valid;
      n_rs = readReg(rsa, wd);
      n_rt = storeRep(readReg(rta, wd), bus.st_size);
      case (bus.imm_mode)
        2'd0: n_imm = sx;
        2'd1: n_imm = imm16;
        2'd2: n_imm = imm16 * 32'h10000;
        default: n_imm = sx * 4;
      endcase
      n_rsa = rsa; n_rta = rta; n_st = bus.st_size;
    end
    if (bus.wb_en && bus.wb_addr != 0) m_rf[bus.wb_addr] = wd;
    if (bus.wb_en && bus.wb_sel && bus.wb_size == 2'd2 && bus.wb_off[0]) m_err = 1;
    @(posedge clk);
    #1;
    m_valid = n_valid; m_rs = n_rs; m_rt = n_rt; m_imm = n_imm;
    m_rsa = n_rsa; m_rta = n_rta; m_st = n_st;
    checkOutput("ex_valid",     32'(bus.ex_valid),     32'(m_valid));
    checkOutput("ex_rs_data",   bus.ex_rs_data,        m_rs);
    checkOutput("ex_rt_data",   bus.ex_rt_data,        m_rt);
    checkOutput("ex_imm",       bus.ex_imm,            m_imm);
    checkOutput("ex_rs_addr",   32'(bus.ex_rs_addr),   32'(m_rsa));
    checkOutput("ex_rt_addr",   32'(bus.ex_rt_addr),   32'(m_rta));
    checkOutput("err_misalign", 32'(bus.err_misalign), 32'(m_err));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus.ex_valid), 32'h0);
    checkOutput({tag, "_rs"},    bus.ex_rs_data,    32'h0);
    checkOutput({tag, "_rt"},    bus.ex_rt_data,    32'h0);
    checkOutput({tag, "_imm"},   bus.ex_imm,        32'h0);
    checkOutput({tag, "_err"},   32'(bus.err_misalign), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    setIdle();
    resetModel();
    #2;
    checkAllZero("reset");
    #1 rst_n = 1'b1;

    // Bypass: write r5 while reading it in the same cycle.
    bus.instr = mkInstr(5, 0, 0, 0); bus.in_valid = 1;
    bus.wb_en = 1; bus.wb_addr = 5; bus.wb_alu = 32'h12345678;
    applyStimulus();
    checkOutput("bypass_r5", bus.ex_rs_data, 32'h12345678);

    // Register 0 ignores writes.
    bus.instr = mkInstr(0, 0, 0, 0); bus.wb_addr = 0; bus.wb_alu = 32'hFFFFFFFF;
    applyStimulus();
    checkOutput("r0_bypass", bus.ex_rs_data, 32'h0);
    bus.wb_en = 0;
    applyStimulus();
    checkOutput("r0_read", bus.ex_rs_data, 32'h0);

    // Load formatting, bypassed into rs.
    bus.instr = mkInstr(10, 0, 0, 0); bus.wb_en = 1; bus.wb_addr = 10;
    bus.wb_sel = 1; bus.wb_mem = 32'h80F17F02; bus.wb_size = 2'd1; bus.wb_off = 2;
    bus.wb_unsigned = 0;
    applyStimulus();
    checkOutput("ld_byte_s", bus.ex_rs_data, 32'hFFFFFFF1);
    checkOutput("ld_err_clear", 32'(bus.err_misalign), 32'h0);
    bus.wb_unsigned = 1;
    applyStimulus();
    checkOutput("ld_byte_u", bus.ex_rs_data, 32'h000000F1);
    bus.wb_unsigned = 0; bus.wb_size = 2'd2; bus.wb_off = 3;
    applyStimulus();
    checkOutput("ld_half_off3", bus.ex_rs_data, 32'hFFFF80F1);
    checkOutput("ld_err_set", 32'(bus.err_misalign), 32'h1);

    // Store replication and immediate modes.
    setIdle();
    bus.wb_en = 1; bus.wb_addr = 7; bus.wb_alu = 32'h000000AB;
    applyStimulus();
    setIdle();
    bus.instr = mkInstr(0, 7, 0, 16'h8004); bus.in_valid = 1; bus.rf_b_sel = 1; bus.st_size = 2'd1;
    applyStimulus();
    checkOutput("st_byte", bus.ex_rt_data, 32'hABABABAB);
    checkOutput("imm_sext", bus.ex_imm, 32'hFFFF8004);
    bus.imm_mode = 2'd1; applyStimulus();
    checkOutput("imm_zext", bus.ex_imm, 32'h00008004);
    bus.imm_mode = 2'd2; applyStimulus();
    checkOutput("imm_lui", bus.ex_imm, 32'h80040000);
    bus.imm_mode = 2'd3; applyStimulus();
    checkOutput("imm_br", bus.ex_imm, 32'hFFFE0010);

    // Stall refresh of a held rs operand.
    setIdle();
    bus.wb_en = 1; bus.wb_addr = 3; bus.wb_alu = 32'h1;
    applyStimulus();
    setIdle();
    bus.instr = mkInstr(3, 0, 0, 16'h0123); bus.in_valid = 1;
    applyStimulus();
    bus.instr = mkInstr(6, 0, 0, 16'h7777); bus.stall = 1;
    bus.wb_en = 1; bus.wb_addr = 3; bus.wb_alu = 32'h9;
    applyStimulus();
    checkOutput("refresh_rs", bus.ex_rs_data, 32'h9);
    checkOutput("refresh_imm_held", bus.ex_imm, 32'h0123);
    checkOutput("refresh_addr_held", 32'(bus.ex_rs_addr), 32'h3);

    // Stall + flush: bubble inserted, write still commits.
    bus.flush = 1; bus.wb_addr = 4; bus.wb_alu = 32'h55;
    applyStimulus();
    checkOutput("flush_valid", 32'(bus.ex_valid), 32'h0);
    checkOutput("flush_rs", bus.ex_rs_data, 32'h0);
    setIdle();
    bus.instr = mkInstr(4, 0, 0, 0);
    applyStimulus();
    checkOutput("flush_write_commit", bus.ex_rs_data, 32'h55);

    // Asynchronous reset mid-operation, released while stalled.
    bus.instr = mkInstr(10, 7, 0, 16'h1234); bus.in_valid = 1;
    applyStimulus();
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    resetModel();
    bus.stall = 1;
    #1 rst_n = 1'b1;
    applyStimulus();
    checkOutput("rst_stall_valid", 32'(bus.ex_valid), 32'h0);
    bus.stall = 0; bus.in_valid = 0;
    for (int i = 0; i < 32; i++) begin
      bus.instr = mkInstr(i, 0, 0, 0);
      applyStimulus();
      checkOutput("rf_cleared", bus.ex_rs_data, 32'h0);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      bus.instr       = $urandom;
      bus.in_valid    = 1'($urandom_range(0, 1));
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.flush       = ($urandom_range(0, 9) == 0);
      bus.imm_mode    = 2'($urandom_range(0, 3));
      bus.rf_b_sel    = 1'($urandom_range(0, 1));
      bus.st_size     = 2'($urandom_range(0, 3));
      bus.wb_en       = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       bus.wb_addr = m_rsa;
        1:       bus.wb_addr = m_rta;
        default: bus.wb_addr = 5'($urandom_range(0, 31));
      endcase
      bus.wb_sel      = 1'($urandom_range(0, 1));
      bus.wb_alu      = $urandom;
      bus.wb_mem      = $urandom;
      bus.wb_size     = 2'($urandom_range(0, 3));
      bus.wb_unsigned = 1'($urandom_range(0, 1));
      bus.wb_off      = 2'($urandom_range(0, 3));
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
